// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl front end: FSM encoding and
// counter-width helpers used by the top and the button debouncer.
package count_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } state_t;

  // Debounce counter only ever needs to hold 0..DEB_CYCLES.
  function automatic int deb_cnt_w(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

  function automatic int presc_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: two-flop synchroniser, level debounce, and a
// single-cycle press strobe on the debounced rising edge.
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // This cycle is the DEB_CYCLES-th consecutive disagreeing sample.
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_stable & ~r_stable_q;

endmodule

// File: rtl/count_ctrl.sv
// Start/stop/clear controller in front of the 4-bit counter: debounced
// buttons drive an IDLE/RUN/PAUSE FSM that emits a prescaled EN strobe.
//
// state | meaning
// IDLE  | stopped, prescaler held at 0
// RUN   | prescaler advancing, EN on terminal phase
// PAUSE | stopped, prescaler phase retained for resume
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DIV        = 4,
  parameter bit ONE_SHOT   = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_start,
  input  logic i_btn_stop,
  input  logic i_btn_clr,
  input  logic i_co,
  output logic o_en,
  output logic o_clr,
  output logic o_running,
  output logic o_done
);

  localparam int PW = presc_w(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic w_start_press;
  logic w_stop_press;
  logic w_clr_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_start),
    .o_press (w_start_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_stop),
    .o_press (w_stop_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_clr),
    .o_press (w_clr_press)
  );

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          r_clr;
  logic          r_done;
  logic          w_clr_nxt;
  logic          w_done_nxt;
  logic          w_en;
  logic          w_go;

  assign w_en = (r_state == RUN) && (r_presc == PRESC_LAST);
  // Stop beats start when both land in the same cycle.
  assign w_go = w_start_press && !w_stop_press;

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_clr_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    if (w_clr_press) begin
      w_state_nxt = IDLE;
      w_presc_nxt = '0;
      w_clr_nxt   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_presc_nxt = '0;
          if (w_go) w_state_nxt = RUN;
        end
        RUN: begin
          if (w_stop_press) begin
            w_state_nxt = PAUSE;
          end else if (ONE_SHOT && w_en && i_co) begin
            w_state_nxt = IDLE;
            w_presc_nxt = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
          end
        end
        PAUSE: begin
          if (w_go) w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_clr   <= w_clr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_en      = w_en;
  assign o_running = (r_state == RUN);
  assign o_clr     = r_clr;
  assign o_done    = r_done;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: default instance (DEB 4, DIV 4) and a
// one-shot instance (DEB 2, DIV 2) each driving a 4-bit counter model.
module tb_count_ctrl;

  logic clk;
  logic rst;
  logic start0, stop0, clrb0, co0, en0, clro0, run0, done0;
  logic start1, stop1, clrb1, co1, en1, clro1, run1, done1;
  logic [3:0] q0, q1;
  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  count_ctrl #(.DEB_CYCLES(4), .DIV(4), .ONE_SHOT(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_btn_start(start0), .i_btn_stop(stop0),
    .i_btn_clr(clrb0), .i_co(co0), .o_en(en0), .o_clr(clro0),
    .o_running(run0), .o_done(done0)
  );

  count_ctrl #(.DEB_CYCLES(2), .DIV(2), .ONE_SHOT(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_btn_start(start1), .i_btn_stop(stop1),
    .i_btn_clr(clrb1), .i_co(co1), .o_en(en1), .o_clr(clro1),
    .o_running(run1), .o_done(done1)
  );

  // Downstream counters: reset by RESET | CLR, count on EN.
  always @(posedge clk) begin
    if (rst || clro0) q0 <= 4'd0;
    else if (en0) q0 <= q0 + 4'd1;
    if (rst || clro1) q1 <= 4'd0;
    else if (en1) q1 <= q1 + 4'd1;
  end
  assign co0 = (q0 == 4'hF);
  assign co1 = (q1 == 4'hF);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int n_en;
    tick(2);
    n_tests++;
    if ({en0, clro0, run0, done0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut0: EN/CLR/RUNNING/DONE=%b expected 0000", {en0, clro0, run0, done0});
    end
    n_tests++;
    if ({en1, clro1, run1, done1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut1: EN/CLR/RUNNING/DONE=%b expected 0000", {en1, clro1, run1, done1});
    end
    rst = 1'b0;
    n_en = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (en0 || en1) n_en++;
    end
    n_tests++;
    if (n_en !== 0) begin
      n_fail++;
      $display("FAIL idle_no_en: EN strobes=%0d expected 0", n_en);
    end
  endtask

  task automatic test_glitch;
    int n_run;
    n_run = 0;
    for (int i = 0; i < 8; i++) begin
      start0 = (i % 2 == 0);
      tick(1);
      if (run0) n_run++;
    end
    start0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (run0) n_run++;
    end
    n_tests++;
    if (n_run !== 0) begin
      n_fail++;
      $display("FAIL glitch_start: RUNNING cycles=%0d expected 0", n_run);
    end
  endtask

  task automatic test_start;
    logic exp_en;
    int n_bad;
    start0 = 1'b1;
    tick(6);
    n_tests++;
    if (run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early: RUNNING=%b expected 0 after edge 6", run0);
    end
    tick(1);
    n_tests++;
    if (run0 !== 1'b1 || en0 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_edge7: RUNNING=%b EN=%b expected 1/0", run0, en0);
    end
    n_bad = 0;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      if (n == 5) start0 = 1'b0;
      exp_en = (n % 4 == 3);
      if (en0 !== exp_en || run0 !== 1'b1) n_bad++;
    end
    n_tests++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL en_cadence: bad cycles=%0d expected 0", n_bad);
    end
  endtask

  task automatic test_pause_resume;
    int guard;
    int n_bad;
    guard = 0;
    while (en0 !== 1'b1 && guard < 10) begin
      tick(1);
      guard++;
    end
    n_tests++;
    if (en0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_en: EN=%b expected 1 within 10 cycles", en0);
    end
    tick(1);
    stop0 = 1'b1;
    tick(6);
    n_tests++;
    if (run0 !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_before: RUNNING=%b expected 1", run0);
    end
    tick(1);
    n_tests++;
    if (run0 !== 1'b0 || en0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_pause: RUNNING=%b EN=%b expected 0/0", run0, en0);
    end
    n_bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) stop0 = 1'b0;
      tick(1);
      if (en0 || run0) n_bad++;
    end
    n_tests++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL pause_hold: active cycles=%0d expected 0", n_bad);
    end
    start0 = 1'b1;
    tick(6);
    n_tests++;
    if (run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_early: RUNNING=%b expected 0", run0);
    end
    tick(1);
    n_tests++;
    if (run0 !== 1'b1 || en0 !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_run: RUNNING=%b EN=%b expected 1/0", run0, en0);
    end
    tick(1);
    n_tests++;
    if (en0 !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_phase: EN=%b expected 1 one cycle after resume", en0);
    end
    start0 = 1'b0;
    tick(10);
  endtask

  task automatic test_clear;
    int n_clr;
    stop0 = 1'b1;
    tick(8);
    stop0 = 1'b0;
    tick(10);
    n_tests++;
    if (run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pause: RUNNING=%b expected 0", run0);
    end
    start0 = 1'b1;
    clrb0  = 1'b1;
    tick(6);
    n_tests++;
    if (clro0 !== 1'b0 || run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_early: CLR=%b RUNNING=%b expected 0/0", clro0, run0);
    end
    tick(1);
    n_tests++;
    if (clro0 !== 1'b1 || run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_pulse: CLR=%b RUNNING=%b expected 1/0", clro0, run0);
    end
    n_clr = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin
        start0 = 1'b0;
        clrb0  = 1'b0;
      end
      tick(1);
      if (clro0 || run0) n_clr++;
    end
    n_tests++;
    if (n_clr !== 0) begin
      n_fail++;
      $display("FAIL clr_single: extra CLR/RUNNING cycles=%0d expected 0", n_clr);
    end
    n_tests++;
    if (q0 !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_counter: Q=%0d expected 0", q0);
    end
    start0 = 1'b1;
    tick(7);
    n_tests++;
    if (run0 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_run: RUNNING=%b expected 1", run0);
    end
    tick(2);
    n_tests++;
    if (en0 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_presc_early: EN=%b expected 0", en0);
    end
    tick(1);
    n_tests++;
    if (en0 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_presc_zero: EN=%b expected 1 three cycles after RUNNING", en0);
    end
    start0 = 1'b0;
  endtask

  task automatic test_one_shot;
    int n_en;
    int guard;
    int n_late;
    start1 = 1'b1;
    tick(4);
    n_tests++;
    if (run1 !== 1'b0) begin
      n_fail++;
      $display("FAIL os_early: RUNNING=%b expected 0", run1);
    end
    tick(1);
    n_tests++;
    if (run1 !== 1'b1 || en1 !== 1'b0) begin
      n_fail++;
      $display("FAIL os_run: RUNNING=%b EN=%b expected 1/0", run1, en1);
    end
    tick(1);
    n_tests++;
    if (en1 !== 1'b1) begin
      n_fail++;
      $display("FAIL os_first_en: EN=%b expected 1", en1);
    end
    n_en  = 1;
    guard = 0;
    while (done1 !== 1'b1 && guard < 100) begin
      tick(1);
      guard++;
      if (guard == 4) start1 = 1'b0;
      if (done1 !== 1'b1 && en1 === 1'b1) n_en++;
    end
    n_tests++;
    if (done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL os_done_timeout: DONE=%b expected 1 within 100 cycles", done1);
    end
    n_tests++;
    if (n_en !== 16 || run1 !== 1'b0 || q1 !== 4'd0) begin
      n_fail++;
      $display("FAIL os_done: EN count=%0d RUNNING=%b Q=%0d expected 16/0/0", n_en, run1, q1);
    end
    tick(1);
    n_tests++;
    if (done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL os_done_width: DONE=%b expected 0", done1);
    end
    n_late = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (en1 || run1 || done1) n_late++;
    end
    n_tests++;
    if (n_late !== 0 || q1 !== 4'd0) begin
      n_fail++;
      $display("FAIL os_after: active cycles=%0d Q=%0d expected 0/0", n_late, q1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start0 = 1'b0; stop0 = 1'b0; clrb0 = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; clrb1 = 1'b0;
    test_reset();
    test_glitch();
    test_start();
    test_pause_resume();
    test_clear();
    test_one_shot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
